// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the FP adder normalize/round stage.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int FRAC_W  = 23;
    localparam int MANT_W  = 28;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;
    localparam int EXPR_W  = 10;
    localparam int LZC_W   = 5;

    localparam int CARRY_BIT  = 27;
    localparam int HIDDEN_BIT = 26;
    localparam int LSB_BIT    = 3;
    localparam int G_BIT      = 2;
    localparam int R_BIT      = 1;
    localparam int S_BIT      = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over the 27 bits below the carry position.
module fp_lzc
    import fp_pkg::*;
(
    input  logic [HIDDEN_BIT:0] val,
    output logic [LZC_W-1:0]    cnt
);

    // Ascending scan: the highest set bit is the last one to write cnt.
    always_comb begin
        cnt = 5'd27;
        for (int i = 0; i <= HIDDEN_BIT; i++) begin
            if (val[i]) cnt = 5'(HIDDEN_BIT - i);
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalize and round-to-nearest-even stage, packs a binary32 result.
// Define FP_FAST_LZC_EN to collapse any left normalization into a single cycle.
//
// state | meaning
// IDLE  | waiting for a sum, in_ready high
// NORM  | one shift per cycle toward hidden bit, exponent limit checks
// ROUND | nearest-even increment at bit 3, back to NORM on carry-out
// DONE  | result presented until out_ready
module fp_norm_round
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_result,
    output logic              out_overflow,
    output logic              out_underflow
);

    state_t                    state, state_nx;
    logic                      sign_r, sign_nx;
    logic signed [EXPR_W-1:0]  exp_r, exp_nx, exp_step;
    logic [MANT_W-1:0]         mant_r, mant_nx, mant_step, mant_rnd;
    logic [31:0]               res_r, res_nx;
    logic                      ovf_r, ovf_nx, unf_r, unf_nx;
    logic                      round_up;

`ifdef FP_FAST_LZC_EN
    logic [LZC_W-1:0] lzc;

    fp_lzc u_lzc (
        .val (mant_r[HIDDEN_BIT:0]),
        .cnt (lzc)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mant_r <= '0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            state  <= state_nx;
            sign_r <= sign_nx;
            exp_r  <= exp_nx;
            mant_r <= mant_nx;
            res_r  <= res_nx;
            ovf_r  <= ovf_nx;
            unf_r  <= unf_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        sign_nx   = sign_r;
        exp_nx    = exp_r;
        mant_nx   = mant_r;
        res_nx    = res_r;
        ovf_nx    = ovf_r;
        unf_nx    = unf_r;
        exp_step  = exp_r;
        mant_step = mant_r;
        round_up  = mant_r[G_BIT] & (mant_r[R_BIT] | mant_r[S_BIT] | mant_r[LSB_BIT]);
        mant_rnd  = mant_r + {24'd0, round_up, 3'b000};

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_nx  = in_sign;
                    exp_nx   = $signed({2'b00, in_exp});
                    mant_nx  = in_mant;
                    ovf_nx   = 1'b0;
                    unf_nx   = 1'b0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (mant_r == '0) begin
                    res_nx   = '0;
                    state_nx = DONE;
                end else if (mant_r[CARRY_BIT] || !mant_r[HIDDEN_BIT]) begin
                    if (mant_r[CARRY_BIT]) begin
                        // Fold the two shifted-out bits into sticky.
                        mant_step = {1'b0, mant_r[MANT_W-1:2], mant_r[R_BIT] | mant_r[S_BIT]};
                        exp_step  = exp_r + 10'sd1;
                    end else begin
`ifdef FP_FAST_LZC_EN
                        mant_step = mant_r << lzc;
                        exp_step  = exp_r - $signed({5'd0, lzc});
`else
                        mant_step = {mant_r[MANT_W-2:0], 1'b0};
                        exp_step  = exp_r - 10'sd1;
`endif
                    end
                    mant_nx = mant_step;
                    exp_nx  = exp_step;
                    if (exp_step >= 10'sd255) begin
                        res_nx   = {sign_r, 8'hFF, 23'd0};
                        ovf_nx   = 1'b1;
                        state_nx = DONE;
                    end else if (exp_step <= 10'sd0) begin
                        res_nx   = {sign_r, 31'd0};
                        unf_nx   = 1'b1;
                        state_nx = DONE;
                    end
                end else begin
                    state_nx = ROUND;
                end
            end
            ROUND: begin
                if (mant_rnd[CARRY_BIT]) begin
                    mant_nx  = mant_rnd;
                    state_nx = NORM;
                end else begin
                    res_nx   = {sign_r, exp_r[EXP_W-1:0], mant_rnd[HIDDEN_BIT-1:LSB_BIT]};
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign out_result    = res_r;
    assign out_overflow  = ovf_r;
    assign out_underflow = unf_r;

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed and randomized checks of fp_norm_round against an arithmetic reference.
module tb_fp_norm_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [7:0]  in_exp = 8'd0;
    logic [27:0] in_mant = 28'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;

    int checks = 0;
    int failures = 0;

    fp_norm_round dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: value-level normalize, nearest-even on the 24-bit significand.
    // Latency -1 marks a rounding carry, whose cycle count is not checked.
    function automatic void model(input logic s, input int e_in, input logic [27:0] m_in,
                                  output logic [31:0] r, output logic ovf, output logic unf,
                                  output int lat);
        int          e;
        int          pre;
        int          lz;
        int          rem;
        logic [27:0] m;
        logic [24:0] frac;
        e = e_in; m = m_in; ovf = 1'b0; unf = 1'b0; r = 32'd0; lat = 1; pre = 0;
        if (m == 28'd0) return;
        if (m[27]) begin
            m = (m >> 1) | (m & 28'd1);
            e = e + 1;
            pre = 1;
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; ovf = 1'b1; return; end
        end else begin
            lz = 26 - ($clog2(int'(m) + 1) - 1);
            if (lz > 0) begin
                if (e - lz <= 0) begin
                    r = {s, 31'd0}; unf = 1'b1;
`ifdef FP_FAST_LZC_EN
                    lat = 1;
`else
                    lat = (e < 1) ? 1 : e;
`endif
                    return;
                end
                m = m << lz;
                e = e - lz;
`ifdef FP_FAST_LZC_EN
                pre = 1;
`else
                pre = lz;
`endif
            end
        end
        frac = {1'b0, m[26:3]};
        rem  = int'(m[2:0]);
        if (rem > 4 || (rem == 4 && m[3])) frac = frac + 25'd1;
        if (frac[24]) begin
            e = e + 1; lat = -1;
            if (e >= 255) begin r = {s, 8'hFF, 23'd0}; ovf = 1'b1; end
            else r = {s, e[7:0], 23'd0};
            return;
        end
        r = {s, e[7:0], frac[22:0]};
        lat = pre + 2;
    endfunction

    task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [27:0] m,
                          input logic [31:0] er, input logic eo, input logic eu, input int elat,
                          input int hold);
        int n;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".valid_seen"}, 32'(out_valid), 32'd1);
        if (elat >= 0) chk({tag, ".latency"}, 32'(n), 32'(elat));
        chk({tag, ".result"}, out_result, er);
        chk({tag, ".overflow"}, 32'(out_overflow), 32'(eo));
        chk({tag, ".underflow"}, 32'(out_underflow), 32'(eu));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, out_result, er);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, ".ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] r, rnd;
        logic        o, u, s;
        int          lat, e, shape, seen;
        logic [27:0] m;

        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", out_result, 32'd0);
        chk("rst.flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        #20 rst_n = 1'b1;

        run_op("one_plus_one", 1'b0, 8'd127, 28'h8000000, 32'h40000000, 1'b0, 1'b0, 3, 10);
`ifdef FP_FAST_LZC_EN
        run_op("cancel", 1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 3, 0);
`else
        run_op("cancel", 1'b0, 8'd127, 28'h0000008, 32'h34000000, 1'b0, 1'b0, 25, 0);
`endif
        run_op("round_carry", 1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 1'b0, 1'b0, -1, 0);
        run_op("tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 1'b0, 1'b0, 2, 0);
        run_op("tie_odd", 1'b1, 8'd127, 28'h400000C, 32'hBF800002, 1'b0, 1'b0, 2, 0);
        run_op("overflow", 1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1'b1, 1'b0, 1, 0);
        run_op("underflow", 1'b0, 8'd1, 28'h2000000, 32'h00000000, 1'b0, 1'b1, 1, 0);
        run_op("zero", 1'b1, 8'd100, 28'h0000000, 32'h00000000, 1'b0, 1'b0, 1, 0);

        // Reset while normalizing must abort with no result.
        @(negedge clk);
        in_valid = 1'b1; in_sign = 1'b0; in_exp = 8'd127; in_mant = 28'h0000008;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst.no_output", 32'(seen), 32'd0);

        for (int k = 0; k < 200; k++) begin
            rnd   = $urandom;
            s     = rnd[31];
            e     = (k % 8 == 0) ? ((rnd[30]) ? 254 : 1) : int'($urandom_range(0, 255));
            shape = int'($urandom_range(0, 4));
            rnd   = $urandom;
            case (shape)
                0: m = {1'b1, rnd[26:0]};
                1: m = {2'b01, rnd[25:0]};
                2: m = {2'b01, rnd[25:0]} >> $urandom_range(1, 26);
                3: m = {1'b0, 24'hFFFFFF, rnd[2:0]};
                default: m = (rnd[3:0] == 4'd0) ? 28'd0 : {1'b0, rnd[26:0]};
            endcase
            model(s, e, m, r, o, u, lat);
            run_op($sformatf("rand%0d", k), s, 8'(e), m, r, o, u, lat, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
